// File: rtl/ycbcr2rgb_csc.sv
// ycbcr2rgb_csc: three-stage YCbCr->RGB converter for BT.601/BT.709 in full or limited range,
// with a valid/ready handshake, whole-pipeline stall, round-to-nearest and saturation.
module ycbcr2rgb_csc #(
    parameter int unsigned DW   = 8,
    parameter int unsigned TW   = 3,
    parameter int unsigned FRAC = 12
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iValid,
    output logic          oReady,
    input  logic [1:0]    iMode,
    input  logic [DW-1:0] iY,
    input  logic [DW-1:0] iCb,
    input  logic [DW-1:0] iCr,
    input  logic [TW-1:0] iTags,
    output logic          oValid,
    input  logic          iReady,
    output logic [DW-1:0] oR,
    output logic [DW-1:0] oG,
    output logic [DW-1:0] oB,
    output logic [TW-1:0] oTags
);

    localparam int unsigned XW = DW + 2;    // signed offset-removed component
    localparam int unsigned CW = FRAC + 3;  // signed coefficient, all |c| < 4
    localparam int unsigned PW = XW + CW;   // full-width product
    localparam int unsigned SW = PW + 2;    // sum of three products plus rounding

    function automatic logic signed [CW-1:0] coef(input real c);
        return CW'($rtoi(c * real'(32'd1 << FRAC) + 0.5));
    endfunction

    localparam logic signed [CW-1:0] KY_FULL  = coef(1.000);
    localparam logic signed [CW-1:0] KY_LIM   = coef(1.164);
    localparam logic signed [CW-1:0] RCR_601F = coef(1.402);
    localparam logic signed [CW-1:0] GCB_601F = coef(0.344);
    localparam logic signed [CW-1:0] GCR_601F = coef(0.714);
    localparam logic signed [CW-1:0] BCB_601F = coef(1.772);
    localparam logic signed [CW-1:0] RCR_601L = coef(1.596);
    localparam logic signed [CW-1:0] GCB_601L = coef(0.392);
    localparam logic signed [CW-1:0] GCR_601L = coef(0.813);
    localparam logic signed [CW-1:0] BCB_601L = coef(2.017);
    localparam logic signed [CW-1:0] RCR_709F = coef(1.575);
    localparam logic signed [CW-1:0] GCB_709F = coef(0.187);
    localparam logic signed [CW-1:0] GCR_709F = coef(0.468);
    localparam logic signed [CW-1:0] BCB_709F = coef(1.856);
    localparam logic signed [CW-1:0] RCR_709L = coef(1.793);
    localparam logic signed [CW-1:0] GCB_709L = coef(0.213);
    localparam logic signed [CW-1:0] GCR_709L = coef(0.533);
    localparam logic signed [CW-1:0] BCB_709L = coef(2.112);

    localparam logic signed [XW-1:0] LIM_OFS = XW'(16 << (DW - 8));
    localparam logic signed [XW-1:0] MID     = XW'(1 << (DW - 1));
    localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC - 1));

    // Drop the fraction bits and clamp into [0, 2^DW-1].
    function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = v >>> FRAC;
        if (s[SW-1])
            return '0;
        else if (|s[SW-2:DW])
            return '1;
        else
            return s[DW-1:0];
    endfunction

    logic                 ce;
    logic                 v1_q, v2_q, v3_q;
    logic [1:0]           mode_q;
    logic [TW-1:0]        tag1_q, tag2_q, tag3_q;
    logic signed [XW-1:0] y_ofs, y_d, cb_d, cr_d, y_q, cb_q, cr_q;
    logic signed [CW-1:0] ky, rcr, gcb, gcr, bcb;
    logic signed [PW-1:0] kyy_d, rcr_d, gcb_d, gcr_d, bcb_d;
    logic signed [PW-1:0] kyy_q, rcr_q, gcb_q, gcr_q, bcb_q;
    logic signed [SW-1:0] r_sum, g_sum, b_sum;
    logic [DW-1:0]        r_d, g_d, b_d, r_q, g_q, b_q;

    assign ce     = ~v3_q | iReady;
    assign oReady = ce;
    assign oValid = v3_q;
    assign oR     = r_q;
    assign oG     = g_q;
    assign oB     = b_q;
    assign oTags  = tag3_q;

    // S1: remove luma footroom (limited range only) and chroma midpoint.
    always_comb begin
        y_ofs = iMode[0] ? LIM_OFS : '0;
        y_d   = $signed({2'b00, iY}) - y_ofs;
        cb_d  = $signed({2'b00, iCb}) - MID;
        cr_d  = $signed({2'b00, iCr}) - MID;
    end

    // S2: coefficient set follows the mode registered with this beat.
    always_comb begin
        ky  = KY_FULL;
        rcr = RCR_601F;
        gcb = GCB_601F;
        gcr = GCR_601F;
        bcb = BCB_601F;
        case (mode_q)
            2'b01: begin
                ky = KY_LIM;  rcr = RCR_601L; gcb = GCB_601L; gcr = GCR_601L; bcb = BCB_601L;
            end
            2'b10: begin
                ky = KY_FULL; rcr = RCR_709F; gcb = GCB_709F; gcr = GCR_709F; bcb = BCB_709F;
            end
            2'b11: begin
                ky = KY_LIM;  rcr = RCR_709L; gcb = GCB_709L; gcr = GCR_709L; bcb = BCB_709L;
            end
            default: ;
        endcase
        kyy_d = PW'(ky)  * PW'(y_q);
        rcr_d = PW'(rcr) * PW'(cr_q);
        gcb_d = PW'(gcb) * PW'(cb_q);
        gcr_d = PW'(gcr) * PW'(cr_q);
        bcb_d = PW'(bcb) * PW'(cb_q);
    end

    // S3: matrix sums with round-to-nearest, then saturation.
    always_comb begin
        r_sum = SW'(kyy_q) + SW'(rcr_q) + RND;
        g_sum = SW'(kyy_q) - SW'(gcb_q) - SW'(gcr_q) + RND;
        b_sum = SW'(kyy_q) + SW'(bcb_q) + RND;
        r_d   = sat(r_sum);
        g_d   = sat(g_sum);
        b_d   = sat(b_sum);
    end

    // Every stage, bubbles included, moves only when ce is high.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            mode_q <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            y_q    <= '0;
            cb_q   <= '0;
            cr_q   <= '0;
            kyy_q  <= '0;
            rcr_q  <= '0;
            gcb_q  <= '0;
            gcr_q  <= '0;
            bcb_q  <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else if (ce) begin
            v1_q   <= iValid;
            mode_q <= iMode;
            tag1_q <= iTags;
            y_q    <= y_d;
            cb_q   <= cb_d;
            cr_q   <= cr_d;
            v2_q   <= v1_q;
            tag2_q <= tag1_q;
            kyy_q  <= kyy_d;
            rcr_q  <= rcr_d;
            gcb_q  <= gcb_d;
            gcr_q  <= gcr_d;
            bcb_q  <= bcb_d;
            v3_q   <= v2_q;
            tag3_q <= tag2_q;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

endmodule
